regfile_mp: RTL

Parametrised multi-port register file that succeeds the fixed 2-read/1-write regfile in the MIPS datapath. It provides NRD combinational read ports, NWR clocked write ports with fixed priority, optional write-to-read bypass, and a per-register busy scoreboard with a pending-producer count. It sits in the decode stage; its outputs feed the decode/execute pipeline flops and the hazard unit.

---
 rtl/mips_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and width helpers used by the register file slice.
package mips_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Address width for a register file of n entries. Never less than 1 bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width able to hold any count from 0 to n inclusive.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags with set-over-clear priority and a registered busy count.
module rf_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned AW      = addr_width(NREGS_DEF),
    parameter int unsigned CW      = count_width(NREGS_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREGS-1:0] clr_i,
    input  logic             set_i,
    input  logic [AW-1:0]    set_addr_i,
    output logic [NREGS-1:0] busy_o,
    output logic [CW-1:0]    busy_cnt_o,
    output logic             any_busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             any_q;
    logic             set_ok;

    assign set_ok = set_i && !((ZERO_R0 != 0) && (set_addr_i == '0));

    // Clears first, then the set, so a producer issued in the same cycle as a write stays busy.
    always_comb begin
        busy_d = busy_q & ~clr_i;
        if (set_ok) begin
            busy_d[set_addr_i] = 1'b1;
        end
        cnt_d = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            any_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            any_q  <= (cnt_d != '0);
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;
    assign any_busy_o = any_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, NWR prioritised writes,
// optional write-to-read bypass and a busy scoreboard for the hazard unit.
module regfile_mp
    import mips_pkg::*;
#(
    parameter  int unsigned WIDTH   = WIDTH_DEF,
    parameter  int unsigned NREGS   = NREGS_DEF,
    parameter  int unsigned NRD     = 2,
    parameter  int unsigned NWR     = 1,
    parameter  int unsigned BYPASS  = 1,
    parameter  int unsigned ZERO_R0 = 1,
    localparam int unsigned AW      = addr_width(NREGS),
    localparam int unsigned CW      = count_width(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*WIDTH-1:0] wd,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_wa,
    output logic [CW-1:0]        busy_cnt,
    output logic                 any_busy
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];
    logic [AW-1:0]    wa_a  [NWR];
    logic [WIDTH-1:0] wd_a  [NWR];
    logic [NWR-1:0]   wv;
    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] busy;

    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign wa_a[j] = wa[j*AW +: AW];
        assign wd_a[j] = wd[j*WIDTH +: WIDTH];
        assign wv[j]   = we[j] && !((ZERO_R0 != 0) && (wa[j*AW +: AW] == '0));
    end

    // Ascending port order: a later port overwrites an earlier one to the same address.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            mem_d[r] = mem_q[r];
        end
        clr = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wv[j]) begin
                mem_d[wa_a[j]] = wd_a[j];
                clr[wa_a[j]]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    rf_scoreboard #(
        .NREGS   (NREGS),
        .ZERO_R0 (ZERO_R0),
        .AW      (AW),
        .CW      (CW)
    ) u_sb (
        .clk        (clk),
        .rst_n      (reset),
        .clr_i      (clr),
        .set_i      (sb_set),
        .set_addr_i (sb_wa),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt),
        .any_busy_o (any_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]    ra_i;
        logic [WIDTH-1:0] rd_v;
        logic             rb_v;

        assign ra_i = ra[i*AW +: AW];

        // Register 0 override is applied last so it beats any bypass hit.
        always_comb begin
            rd_v = mem_q[ra_i];
            rb_v = busy[ra_i];
            if (BYPASS != 0) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (wv[j] && (wa_a[j] == ra_i)) begin
                        rd_v = wd_a[j];
                        rb_v = 1'b0;
                    end
                end
            end
            if ((ZERO_R0 != 0) && (ra_i == '0)) begin
                rd_v = '0;
                rb_v = 1'b0;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = rd_v;
        assign rbusy[i]             = rb_v;
    end

endmodule
